// File: rtl/div_seq_ctrl_pkg.sv
// Shared types and opcode decode for the sequential RV32M divider.
package div_seq_ctrl_pkg;

  // opSel encodings
  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PREPA = 3'd1,
    ST_PREPB = 3'd2,
    ST_ITER  = 3'd3,
    ST_FIXUP = 3'd4,
    ST_DONE  = 3'd5
  } divState_t;

  // Signed variants have opSel[0] clear.
  function automatic logic isSigned(input logic [1:0] op);
    return ~op[0];
  endfunction

  // Remainder variants have opSel[1] set.
  function automatic logic isRem(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/div_seq_ctrl_if.sv
// Issue/result handshake between the execute stage and the divider.
interface div_seq_ctrl_if #(parameter int NUM_SIZE = 32);
  logic                startValid;
  logic                startReady;
  logic [1:0]          opSel;
  logic [NUM_SIZE-1:0] dividend;
  logic [NUM_SIZE-1:0] divisor;
  logic                kill;
  logic                resValid;
  logic                resReady;
  logic [NUM_SIZE-1:0] result;
  logic                divByZero;

  modport master (
    output startValid, opSel, dividend, divisor, kill, resReady,
    input  startReady, resValid, result, divByZero
  );

  modport slave (
    input  startValid, opSel, dividend, divisor, kill, resReady,
    output startReady, resValid, result, divByZero
  );
endinterface

// File: rtl/div_seq_ctrl_addsub.sv
// Combinational add/subtract shared by negation, trial subtraction and fixup.
module addSubComp #(parameter int NUM_SIZE = 33) (
  input  logic [NUM_SIZE-1:0] a,
  input  logic [NUM_SIZE-1:0] b,
  input  logic                sub,
  output logic [NUM_SIZE-1:0] sum
);
  // Plain two's-complement add or subtract.
  always_comb sum = sub ? (a - b) : (a + b);
endmodule

// File: rtl/div_seq_ctrl.sv
// Multi-cycle restoring divider for DIV/DIVU/REM/REMU using one shared
// N+1-bit subtractor for operand negation, trial subtraction and sign fixup.
module div_seq_ctrl
  import div_seq_ctrl_pkg::*;
#(
  parameter int NUM_SIZE = 32
) (
  input  logic         clk,
  input  logic         rst,
  div_seq_ctrl_if.slave bus
);
  localparam int CW = $clog2(NUM_SIZE);
  localparam int AW = NUM_SIZE + 1;

  divState_t           state;
  logic [1:0]          op;
  logic [NUM_SIZE-1:0] qReg;     // dividend magnitude, then quotient
  logic [NUM_SIZE-1:0] rReg;     // partial remainder, then selected result
  logic [NUM_SIZE-1:0] dReg;     // divisor magnitude
  logic [NUM_SIZE-1:0] origA;    // untouched dividend for the divide-by-zero remainder
  logic [CW-1:0]       count;
  logic                aNeg, qNeg, rNeg, dZero, fixPh;
  logic                startReady, resValid, divByZero;
  logic [NUM_SIZE-1:0] result;

  logic [AW-1:0]       addA, addB, addSum;
  logic                accept, trialNeg, fixNeg;

  assign accept   = bus.startValid & startReady;
  assign trialNeg = addSum[AW-1];
  assign fixNeg   = isRem(op) ? rNeg : qNeg;

  // Shared-unit operands depend only on state and registers, never on inputs.
  always_comb begin
    addA = '0;
    addB = '0;
    case (state)
      ST_PREPA: addB = {1'b0, qReg};
      ST_PREPB: addB = {1'b0, dReg};
      ST_ITER: begin
        addA = {rReg, qReg[NUM_SIZE-1]};
        addB = {1'b0, dReg};
      end
      ST_FIXUP: addB = {1'b0, rReg};
      default: ;
    endcase
  end

  addSubComp #(.NUM_SIZE(AW)) uAddSub (
    .a   (addA),
    .b   (addB),
    .sub (1'b1),
    .sum (addSum)
  );

  // Sequencer: operand prep, NUM_SIZE restoring steps, two-phase fixup, hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      op         <= '0;
      qReg       <= '0;
      rReg       <= '0;
      dReg       <= '0;
      origA      <= '0;
      count      <= '0;
      aNeg       <= 1'b0;
      qNeg       <= 1'b0;
      rNeg       <= 1'b0;
      dZero      <= 1'b0;
      fixPh      <= 1'b0;
      startReady <= 1'b1;
      resValid   <= 1'b0;
      divByZero  <= 1'b0;
      result     <= '0;
    end else if (bus.kill && state != ST_IDLE) begin
      state      <= ST_IDLE;
      startReady <= 1'b1;
      resValid   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (accept) begin
          op         <= bus.opSel;
          qReg       <= bus.dividend;
          origA      <= bus.dividend;
          dReg       <= bus.divisor;
          startReady <= 1'b0;
          state      <= ST_PREPA;
        end
        ST_PREPA: begin
          aNeg <= isSigned(op) & qReg[NUM_SIZE-1];
          if (isSigned(op) && qReg[NUM_SIZE-1]) qReg <= addSum[NUM_SIZE-1:0];
          state <= ST_PREPB;
        end
        ST_PREPB: begin
          qNeg  <= aNeg ^ (isSigned(op) & dReg[NUM_SIZE-1]);
          rNeg  <= aNeg;
          dZero <= (dReg == '0);
          if (isSigned(op) && dReg[NUM_SIZE-1]) dReg <= addSum[NUM_SIZE-1:0];
          rReg  <= '0;
          count <= '0;
          state <= ST_ITER;
        end
        ST_ITER: begin
          if (!trialNeg) begin
            rReg <= addSum[NUM_SIZE-1:0];
            qReg <= {qReg[NUM_SIZE-2:0], 1'b1};
          end else begin
            rReg <= {rReg[NUM_SIZE-2:0], qReg[NUM_SIZE-1]};
            qReg <= {qReg[NUM_SIZE-2:0], 1'b0};
          end
          count <= count + 1'b1;
          if (count == CW'(NUM_SIZE - 1)) begin
            fixPh <= 1'b0;
            state <= ST_FIXUP;
          end
        end
        ST_FIXUP: begin
          // Phase 0 parks the chosen magnitude in rReg so the shared unit
          // can negate it in phase 1 with a state-only operand mux.
          if (!fixPh) begin
            if (!isRem(op)) rReg <= qReg;
            fixPh <= 1'b1;
          end else begin
            if (dZero) result <= isRem(op) ? origA : '1;
            else       result <= fixNeg ? addSum[NUM_SIZE-1:0] : rReg;
            divByZero <= dZero;
            resValid  <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: if (bus.resReady) begin
          resValid   <= 1'b0;
          startReady <= 1'b1;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.startReady = startReady;
  assign bus.resValid   = resValid;
  assign bus.result     = result;
  assign bus.divByZero  = divByZero;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Randomized and directed checks of div_seq_ctrl against an arithmetic model.
module tb_div_seq_ctrl;
  import div_seq_ctrl_pkg::*;

  localparam int LAT = 36;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nCmp = 0;
  int   nErr = 0;

  div_seq_ctrl_if #(.NUM_SIZE(32)) bus();

  div_seq_ctrl #(.NUM_SIZE(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference: RV32M semantics from plain integer arithmetic.
  function automatic void refDiv(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] res, output logic dz);
    int signed sa, sb, q, r;
    logic [31:0] uq, ur;
    sa = a; sb = b;
    dz = (b == 0);
    if (o[0] == 1'b0) begin
      if (b == 0)                            begin q = -1; r = sa; end
      else if (a == 32'h8000_0000 && sb == -1) begin q = sa; r = 0; end
      else                                   begin q = sa / sb; r = sa % sb; end
      res = o[1] ? r : q;
    end else begin
      if (b == 0) begin uq = 32'hFFFF_FFFF; ur = a; end
      else        begin uq = a / b; ur = a % b; end
      res = o[1] ? ur : uq;
    end
  endfunction

  // Issue one op at the current (post-edge) time and wait for resValid.
  task automatic runOp(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output logic dz, output int lat, output logic busyRdy);
    bus.startValid = 1'b1; bus.opSel = o; bus.dividend = a; bus.divisor = b;
    @(posedge clk); #1;
    bus.startValid = 1'b0;
    busyRdy = bus.startReady;
    lat = 0;
    while (!bus.resValid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    res = bus.result;
    dz  = bus.divByZero;
  endtask

  task automatic checkOp(input string nm, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] res, expRes;
    logic dz, expDz, busyRdy;
    int lat;
    refDiv(o, a, b, expRes, expDz);
    bus.resReady = 1'b1;
    runOp(o, a, b, res, dz, lat, busyRdy);
    nCmp += 4;
    if (res !== expRes) begin nErr++; $display("FAIL %s result: got %h want %h", nm, res, expRes); end
    if (dz !== expDz)   begin nErr++; $display("FAIL %s divByZero: got %b want %b", nm, dz, expDz); end
    if (lat !== LAT)    begin nErr++; $display("FAIL %s latency: got %0d want %0d", nm, lat, LAT); end
    if (busyRdy !== 1'b0) begin nErr++; $display("FAIL %s startReady busy: got %b want 0", nm, busyRdy); end
    @(posedge clk); #1;
    nCmp++;
    if (bus.resValid !== 1'b0 || bus.startReady !== 1'b1) begin
      nErr++; $display("FAIL %s return: resValid=%b startReady=%b want 0/1", nm, bus.resValid, bus.startReady);
    end
  endtask

  task automatic test_reset();
    bus.startValid = 0; bus.opSel = 0; bus.dividend = 0; bus.divisor = 0;
    bus.kill = 0; bus.resReady = 1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    nCmp += 4;
    if (bus.resValid !== 1'b0)   begin nErr++; $display("FAIL reset resValid: got %b want 0", bus.resValid); end
    if (bus.result !== 32'h0)    begin nErr++; $display("FAIL reset result: got %h want 0", bus.result); end
    if (bus.divByZero !== 1'b0)  begin nErr++; $display("FAIL reset divByZero: got %b want 0", bus.divByZero); end
    if (bus.startReady !== 1'b1) begin nErr++; $display("FAIL reset startReady: got %b want 1", bus.startReady); end
  endtask

  task automatic test_directed();
    checkOp("divu_100_7",   OP_DIVU, 32'd100, 32'd7);
    checkOp("remu_100_7",   OP_REMU, 32'd100, 32'd7);
    checkOp("div_m7_2",     OP_DIV,  32'hFFFF_FFF9, 32'd2);
    checkOp("rem_m7_2",     OP_REM,  32'hFFFF_FFF9, 32'd2);
    checkOp("div_5_0",      OP_DIV,  32'd5, 32'd0);
    checkOp("rem_5_0",      OP_REM,  32'd5, 32'd0);
    checkOp("div_ovf",      OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF);
    checkOp("rem_ovf",      OP_REM,  32'h8000_0000, 32'hFFFF_FFFF);
    checkOp("divu_max_1",   OP_DIVU, 32'hFFFF_FFFF, 32'd1);
    checkOp("remu_small_big", OP_REMU, 32'd3, 32'hFFFF_FFF0);
  endtask

  function automatic logic [31:0] pickVal();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      checkOp("random", 2'($urandom_range(0, 3)), pickVal(), pickVal());
    end
  endtask

  task automatic test_back_pressure();
    logic [31:0] res;
    logic dz, busyRdy;
    int lat;
    bus.resReady = 1'b0;
    runOp(OP_DIVU, 32'd100, 32'd7, res, dz, lat, busyRdy);
    nCmp += 2;
    if (res !== 32'd14) begin nErr++; $display("FAIL hold first result: got %h want 0000000e", res); end
    if (lat !== LAT)    begin nErr++; $display("FAIL hold latency: got %0d want %0d", lat, LAT); end
    for (int k = 0; k < 5; k++) begin
      bus.startValid = 1'b1; bus.opSel = OP_DIV; bus.dividend = 32'd77; bus.divisor = 32'd0;
      @(posedge clk); #1;
      bus.startValid = 1'b0;
      nCmp += 3;
      if (bus.resValid !== 1'b1)   begin nErr++; $display("FAIL hold resValid: got %b want 1", bus.resValid); end
      if (bus.result !== 32'd14)   begin nErr++; $display("FAIL hold result: got %h want 0000000e", bus.result); end
      if (bus.startReady !== 1'b0) begin nErr++; $display("FAIL hold startReady: got %b want 0", bus.startReady); end
    end
    bus.resReady = 1'b1;
    @(posedge clk); #1;
    nCmp += 2;
    if (bus.resValid !== 1'b0)   begin nErr++; $display("FAIL release resValid: got %b want 0", bus.resValid); end
    if (bus.startReady !== 1'b1) begin nErr++; $display("FAIL release startReady: got %b want 1", bus.startReady); end
    @(posedge clk); #1;
    nCmp++;
    if (bus.startReady !== 1'b1) begin nErr++; $display("FAIL ignored pulse started op: startReady %b want 1", bus.startReady); end
  endtask

  task automatic test_abort();
    // Async reset in the middle of the iteration.
    bus.resReady = 1'b1;
    bus.startValid = 1'b1; bus.opSel = OP_DIVU; bus.dividend = 32'd1000; bus.divisor = 32'd3;
    @(posedge clk); #1;
    bus.startValid = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    nCmp++;
    if (bus.resValid !== 1'b0) begin nErr++; $display("FAIL rst midIter resValid: got %b want 0", bus.resValid); end
    #1 rst = 1'b0;
    @(posedge clk); #1;
    nCmp++;
    if (bus.startReady !== 1'b1) begin nErr++; $display("FAIL rst midIter startReady: got %b want 1", bus.startReady); end

    // kill while in fixup (34 edges after accept lands in FIXUP).
    bus.startValid = 1'b1; bus.opSel = OP_DIV; bus.dividend = 32'd50; bus.divisor = 32'd5;
    @(posedge clk); #1;
    bus.startValid = 1'b0;
    repeat (34) @(posedge clk);
    #1 bus.kill = 1'b1;
    @(posedge clk); #1;
    bus.kill = 1'b0;
    nCmp += 2;
    if (bus.resValid !== 1'b0)   begin nErr++; $display("FAIL kill fixup resValid: got %b want 0", bus.resValid); end
    if (bus.startReady !== 1'b1) begin nErr++; $display("FAIL kill fixup startReady: got %b want 1", bus.startReady); end
    repeat (3) @(posedge clk);
    #1;
    nCmp++;
    if (bus.resValid !== 1'b0) begin nErr++; $display("FAIL kill stale resValid: got %b want 0", bus.resValid); end

    // kill in IDLE is a no-op.
    bus.kill = 1'b1;
    @(posedge clk); #1;
    bus.kill = 1'b0;
    checkOp("divu_9_3_after_abort", OP_DIVU, 32'd9, 32'd3);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_pressure();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "timeout");
  end

endmodule
